// File: rtl/carpark_gate_ctrl.sv
// Lane controller for a single-barrier car park: occupancy counting plus
// round-robin arbitration of the shared barrier between entry and exit.
module carpark_gate_ctrl #(
  parameter int CAPACITY     = 4,
  parameter int CNT_W        = 3,
  parameter int GATE_TIMEOUT = 8,
  parameter int CLOSE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic             exit,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             gate_open,
  output logic             dir_in,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             denied,
  output logic             err
);

  localparam int TMAX = (GATE_TIMEOUT > CLOSE_CYCLES) ? GATE_TIMEOUT : CLOSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] OPEN_IN  = 2'd1;
  localparam logic [1:0] OPEN_OUT = 2'd2;
  localparam logic [1:0] CLOSING  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             last_in_q, last_in_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             denied_q, denied_d;
  logic             err_q, err_d;
  logic             grant_in, grant_out;

  assign full      = (count_q == CNT_W'(CAPACITY));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign denied    = denied_q;
  assign err       = err_q;
  assign gate_open = (state_q == OPEN_IN) || (state_q == OPEN_OUT);
  assign dir_in    = (state_q == OPEN_IN);

  // Sensors are authoritative: the count follows the pulses in every state.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (enter && !exit) begin
      if (full) err_d = 1'b1;
      else      count_d = count_q + 1'b1;
    end else if (exit && !enter) begin
      if (empty) err_d = 1'b1;
      else       count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_in_d = last_in_q;
    denied_d  = 1'b0;
    grant_in  = entry_req && !full;
    grant_out = exit_req;
    case (state_q)
      IDLE: begin
        if (grant_in && (!grant_out || !last_in_q)) begin
          state_d   = OPEN_IN;
          last_in_d = 1'b1;
          timer_d   = '0;
        end else if (grant_out) begin
          state_d   = OPEN_OUT;
          last_in_d = 1'b0;
          timer_d   = '0;
        end else begin
          denied_d  = entry_req && full;
        end
      end
      OPEN_IN: begin
        if (enter || timer_q == TW'(GATE_TIMEOUT - 1)) begin
          state_d = CLOSING;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      OPEN_OUT: begin
        if (exit || timer_q == TW'(GATE_TIMEOUT - 1)) begin
          state_d = CLOSING;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CLOSING: begin
        if (timer_q == TW'(CLOSE_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      last_in_q <= 1'b0;
      count_q   <= '0;
      denied_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_in_q <= last_in_d;
      count_q   <= count_d;
      denied_q  <= denied_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_carpark_gate_ctrl.sv
// Randomized bench for carpark_gate_ctrl against an elapsed-time reference
// model of the barrier and an integer occupancy model.
module tb_carpark_gate_ctrl;

  localparam int CAPACITY     = 4;
  localparam int CNT_W        = 3;
  localparam int GATE_TIMEOUT = 8;
  localparam int CLOSE_CYCLES = 2;

  logic             clk = 1'b0;
  logic             reset, enter, exit, entry_req, exit_req;
  logic             gate_open, dir_in, full, empty, denied, err;
  logic [CNT_W-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who holds the barrier and how long it has been in that phase.
  string m_phase;      // "idle", "in", "out", "closing"
  int    m_elapsed;
  int    m_cars;
  bit    m_err, m_denied, m_prefer_exit;

  carpark_gate_ctrl #(
    .CAPACITY    (CAPACITY),
    .CNT_W       (CNT_W),
    .GATE_TIMEOUT(GATE_TIMEOUT),
    .CLOSE_CYCLES(CLOSE_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enter    (enter),
    .exit     (exit),
    .entry_req(entry_req),
    .exit_req (exit_req),
    .gate_open(gate_open),
    .dir_in   (dir_in),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .denied   (denied),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input bit ex,
                            input bit er, input bit xr);
    bit was_full;
    bit pass;
    if (rst) begin
      m_phase = "idle"; m_elapsed = 0; m_cars = 0;
      m_err = 0; m_denied = 0; m_prefer_exit = 0;
      return;
    end
    was_full = (m_cars == CAPACITY);
    m_denied = 0;
    if (m_phase == "idle") begin
      if (er && !was_full && (!xr || !m_prefer_exit)) begin
        m_phase = "in"; m_elapsed = 0; m_prefer_exit = 1;
      end else if (xr) begin
        m_phase = "out"; m_elapsed = 0; m_prefer_exit = 0;
      end else begin
        m_denied = er && was_full;
      end
    end else if (m_phase == "in" || m_phase == "out") begin
      m_elapsed++;
      pass = (m_phase == "in") ? en : ex;
      if (pass || m_elapsed == GATE_TIMEOUT) begin
        m_phase = "closing"; m_elapsed = 0;
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == CLOSE_CYCLES) begin
        m_phase = "idle"; m_elapsed = 0;
      end
    end
    if (en && !ex) begin
      if (m_cars == CAPACITY) m_err = 1; else m_cars++;
    end else if (ex && !en) begin
      if (m_cars == 0) m_err = 1; else m_cars--;
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit ex,
                      input bit er, input bit xr);
    bit exp_open;
    reset = rst; enter = en; exit = ex; entry_req = er; exit_req = xr;
    @(posedge clk);
    model_edge(rst, en, ex, er, xr);
    #1;
    exp_open = (m_phase == "in") || (m_phase == "out");
    check("gate_open", int'(gate_open), int'(exp_open));
    if (exp_open) check("dir_in", int'(dir_in), int'(m_phase == "in"));
    check("count",  int'(count),  m_cars);
    check("full",   int'(full),   int'(m_cars == CAPACITY));
    check("empty",  int'(empty),  int'(m_cars == 0));
    check("denied", int'(denied), int'(m_denied));
    check("err",    int'(err),    int'(m_err));
    @(negedge clk);
  endtask

  // Per-phase percent weights: enter, exit, entry_req, exit_req.
  int w_en[6] = '{40, 10, 5, 30, 20, 2};
  int w_ex[6] = '{5, 40, 5, 30, 20, 2};
  int w_er[6] = '{80, 20, 90, 90, 50, 60};
  int w_xr[6] = '{10, 70, 5, 90, 50, 10};

  initial begin
    reset = 1'b1; enter = 1'b0; exit = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 400; c++) begin
        step($urandom_range(99) < 1,
             $urandom_range(99) < w_en[p],
             $urandom_range(99) < w_ex[p],
             $urandom_range(99) < w_er[p],
             $urandom_range(99) < w_xr[p]);
      end
    end
    step(1, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
